// File: rtl/mouse_device_sm_if.sv
// Byte-link and movement-source signals of the device-side PS/2 mouse model.
// The slave modport is the mouse model; the master modport is the link/host side.
interface mouse_device_sm_if;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent;
  logic [7:0] byte_read;
  logic       byte_ready;
  logic [1:0] byte_error_code;
  logic       move_valid;
  logic [8:0] move_dx;
  logic [8:0] move_dy;
  logic [3:0] move_dz;
  logic [2:0] move_buttons;
  logic       move_accept;
  logic       streaming;
  logic       intelli_mode;
  logic [7:0] sample_rate;

  modport slave (
    input  byte_sent, byte_read, byte_ready, byte_error_code,
    input  move_valid, move_dx, move_dy, move_dz, move_buttons,
    output send_byte, byte_to_send, move_accept,
    output streaming, intelli_mode, sample_rate
  );

  modport master (
    output byte_sent, byte_read, byte_ready, byte_error_code,
    output move_valid, move_dx, move_dy, move_dz, move_buttons,
    input  send_byte, byte_to_send, move_accept,
    input  streaming, intelli_mode, sample_rate
  );
endinterface

// File: rtl/mouse_device_sm.sv
// Device-side PS/2 mouse: answers host commands and streams 3/4-byte movement
// packets through a one-byte-at-a-time transmitter handshake.
module mouse_device_sm #(
  parameter int unsigned SELFTEST_CYCLES = 32'd500000,
  parameter logic [7:0]  DEFAULT_RATE    = 8'h64
) (
  input  logic             clk,
  input  logic             rst_n,
  mouse_device_sm_if.slave bus
);

  localparam logic [7:0]  ACK           = 8'hFA;
  localparam logic [7:0]  RESEND        = 8'hFE;
  localparam logic [7:0]  BAT_OK        = 8'hAA;
  localparam logic [31:0] SELFTEST_LAST = SELFTEST_CYCLES - 32'd1;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    DECODE        = 3'd1,
    TX_START      = 3'd2,
    TX_WAIT       = 3'd3,
    SELFTEST_WAIT = 3'd4,
    RATE_ARG      = 3'd5,
    PKT_LOAD      = 3'd6
  } state_t;

  function automatic logic magic_seq(input logic [23:0] hist);
    return hist == 24'hC8_64_50;
  endfunction

  function automatic logic [31:0] build_packet(input logic [8:0] dx, input logic [8:0] dy,
                                               input logic [3:0] dz, input logic [2:0] btn);
    return {{4{dz[3]}}, dz, dy[7:0], dx[7:0], 2'b00, dy[8], dx[8], 1'b1, btn};
  endfunction

  state_t      state_r, state_s;
  state_t      ret_r, ret_s;
  logic        send_byte_r, send_byte_s;
  logic [7:0]  byte_to_send_r, byte_to_send_s;
  logic        move_accept_r, move_accept_s;
  logic        streaming_r, streaming_s;
  logic        intelli_r, intelli_s;
  logic [7:0]  rate_r, rate_s;
  logic [23:0] hist_r, hist_s;
  logic        pend_valid_r, pend_valid_s;
  logic [7:0]  pend_byte_r, pend_byte_s;
  logic [7:0]  cmd_r, cmd_s;
  logic        cmd_err_r, cmd_err_s;
  logic        arg_mode_r, arg_mode_s;
  logic [23:0] tx_buf_r, tx_buf_s;
  logic [1:0]  tx_left_r, tx_left_s;
  logic [31:0] timer_r, timer_s;
  logic [31:0] pkt_r, pkt_s;
  logic        pkt_long_r, pkt_long_s;
  logic        rx_bad_s, rx_good_s, latch_s;

  assign rx_bad_s  = bus.byte_error_code != 2'b00;
  assign rx_good_s = bus.byte_ready && !rx_bad_s;
  // States that do not consume host bytes directly park good ones in the pending slot.
  assign latch_s   = rx_good_s && !(state_r inside {IDLE, RATE_ARG, SELFTEST_WAIT});

  assign bus.send_byte    = send_byte_r;
  assign bus.byte_to_send = byte_to_send_r;
  assign bus.move_accept  = move_accept_r;
  assign bus.streaming    = streaming_r;
  assign bus.intelli_mode = intelli_r;
  assign bus.sample_rate  = rate_r;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      ret_r          <= IDLE;
      send_byte_r    <= 1'b0;
      byte_to_send_r <= 8'h00;
      move_accept_r  <= 1'b0;
      streaming_r    <= 1'b0;
      intelli_r      <= 1'b0;
      rate_r         <= DEFAULT_RATE;
      hist_r         <= 24'h000000;
      pend_valid_r   <= 1'b0;
      pend_byte_r    <= 8'h00;
      cmd_r          <= 8'h00;
      cmd_err_r      <= 1'b0;
      arg_mode_r     <= 1'b0;
      tx_buf_r       <= 24'h000000;
      tx_left_r      <= 2'd0;
      timer_r        <= 32'd0;
      pkt_r          <= 32'd0;
      pkt_long_r     <= 1'b0;
    end else begin
      state_r        <= state_s;
      ret_r          <= ret_s;
      send_byte_r    <= send_byte_s;
      byte_to_send_r <= byte_to_send_s;
      move_accept_r  <= move_accept_s;
      streaming_r    <= streaming_s;
      intelli_r      <= intelli_s;
      rate_r         <= rate_s;
      hist_r         <= hist_s;
      pend_valid_r   <= pend_valid_s;
      pend_byte_r    <= pend_byte_s;
      cmd_r          <= cmd_s;
      cmd_err_r      <= cmd_err_s;
      arg_mode_r     <= arg_mode_s;
      tx_buf_r       <= tx_buf_s;
      tx_left_r      <= tx_left_s;
      timer_r        <= timer_s;
      pkt_r          <= pkt_s;
      pkt_long_r     <= pkt_long_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s        = state_r;
    ret_s          = ret_r;
    send_byte_s    = 1'b0;
    byte_to_send_s = byte_to_send_r;
    move_accept_s  = 1'b0;
    streaming_s    = streaming_r;
    intelli_s      = intelli_r;
    rate_s         = rate_r;
    hist_s         = hist_r;
    pend_valid_s   = pend_valid_r | latch_s;
    pend_byte_s    = latch_s ? bus.byte_read : pend_byte_r;
    cmd_s          = cmd_r;
    cmd_err_s      = cmd_err_r;
    arg_mode_s     = arg_mode_r;
    tx_buf_s       = tx_buf_r;
    tx_left_s      = tx_left_r;
    timer_s        = timer_r;
    pkt_s          = pkt_r;
    pkt_long_s     = pkt_long_r;

    case (state_r)
      IDLE: begin
        if (bus.byte_ready) begin
          cmd_s      = bus.byte_read;
          cmd_err_s  = rx_bad_s;
          arg_mode_s = 1'b0;
          state_s    = DECODE;
        end else if (streaming_r && bus.move_valid) begin
          pkt_s         = build_packet(bus.move_dx, bus.move_dy, bus.move_dz, bus.move_buttons);
          pkt_long_s    = intelli_r;
          move_accept_s = 1'b1;
          state_s       = PKT_LOAD;
        end else begin
          state_s = IDLE;
        end
      end

      RATE_ARG: begin
        if (bus.byte_ready) begin
          cmd_s      = bus.byte_read;
          cmd_err_s  = rx_bad_s;
          arg_mode_s = 1'b1;
          state_s    = DECODE;
        end else begin
          state_s = RATE_ARG;
        end
      end

      DECODE: begin
        send_byte_s    = 1'b1;
        byte_to_send_s = ACK;
        tx_buf_s       = 24'h000000;
        tx_left_s      = 2'd0;
        ret_s          = IDLE;
        state_s        = TX_WAIT;
        if (cmd_err_r) begin
          byte_to_send_s = RESEND;
          if (arg_mode_r) begin
            ret_s = RATE_ARG;
          end else begin
            ret_s = IDLE;
          end
        end else if (arg_mode_r) begin
          rate_s    = cmd_r;
          hist_s    = {hist_r[15:0], cmd_r};
          intelli_s = intelli_r | magic_seq({hist_r[15:0], cmd_r});
        end else begin
          case (cmd_r)
            8'hFF: begin
              ret_s       = SELFTEST_WAIT;
              streaming_s = 1'b0;
              intelli_s   = 1'b0;
              hist_s      = 24'h000000;
              rate_s      = DEFAULT_RATE;
            end
            8'hF4: streaming_s = 1'b1;
            8'hF5: streaming_s = 1'b0;
            8'hF6: begin
              streaming_s = 1'b0;
              rate_s      = DEFAULT_RATE;
            end
            8'hF3: ret_s = RATE_ARG;
            8'hF2: begin
              tx_buf_s  = {16'h0000, (intelli_r ? 8'h03 : 8'h00)};
              tx_left_s = 2'd1;
            end
            default: byte_to_send_s = RESEND;
          endcase
        end
      end

      TX_START: begin
        send_byte_s    = 1'b1;
        byte_to_send_s = tx_buf_r[7:0];
        tx_buf_s       = {8'h00, tx_buf_r[23:8]};
        tx_left_s      = tx_left_r - 2'd1;
        state_s        = TX_WAIT;
      end

      TX_WAIT: begin
        if (bus.byte_sent) begin
          if (pend_valid_r || rx_good_s) begin
            // A host byte preempts whatever is left; if only the rate argument
            // was outstanding, the preempting byte is that argument.
            cmd_s        = rx_good_s ? bus.byte_read : pend_byte_r;
            cmd_err_s    = 1'b0;
            arg_mode_s   = (ret_r == RATE_ARG) && (tx_left_r == 2'd0);
            pend_valid_s = 1'b0;
            state_s      = DECODE;
          end else if (tx_left_r != 2'd0) begin
            state_s = TX_START;
          end else if (ret_r == SELFTEST_WAIT) begin
            timer_s = 32'd0;
            state_s = SELFTEST_WAIT;
          end else begin
            state_s = ret_r;
          end
        end else begin
          state_s = TX_WAIT;
        end
      end

      SELFTEST_WAIT: begin
        if (rx_good_s) begin
          cmd_s      = bus.byte_read;
          cmd_err_s  = 1'b0;
          arg_mode_s = 1'b0;
          state_s    = DECODE;
        end else if (timer_r == SELFTEST_LAST) begin
          tx_buf_s  = {8'h00, 8'h00, BAT_OK};
          tx_left_s = 2'd2;
          ret_s     = IDLE;
          state_s   = TX_START;
        end else begin
          timer_s = timer_r + 32'd1;
        end
      end

      PKT_LOAD: begin
        send_byte_s    = 1'b1;
        byte_to_send_s = pkt_r[7:0];
        tx_buf_s       = pkt_r[31:8];
        tx_left_s      = pkt_long_r ? 2'd3 : 2'd2;
        ret_s          = IDLE;
        state_s        = TX_WAIT;
      end

      default: state_s = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mouse_device_sm.sv
// Randomised scoreboard bench for mouse_device_sm: a command/packet model queues
// expected bytes, and a monitor pops them whenever the DUT requests a transmit.
module tb_mouse_device_sm;
  localparam int ST = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mouse_device_sm_if bus();

  mouse_device_sm #(.SELFTEST_CYCLES(ST), .DEFAULT_RATE(8'h64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sent_cnt = 0;
  int done_cnt = 0;
  int accept_cnt = 0;
  int last_done_cyc = 0;
  int tx_delay = 2;
  bit tx_busy = 1'b0;
  logic [7:0] exp_q[$];

  bit m_stream, m_intelli, m_rate_arg;
  logic [7:0] m_rate;
  logic [7:0] m_hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every transmit request must match the head of the scoreboard.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.send_byte) begin
        sent_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h expected none", bus.byte_to_send);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", bus.byte_to_send, e);
          if (e == 8'hAA) chk("selftest_gap", (cyc - last_done_cyc) >= ST, 32'd1);
        end
      end
      if (rst_n && bus.move_accept) accept_cnt++;
    end
  end

  // Transmitter model: finishes each requested byte after tx_delay cycles.
  initial begin : tx_model
    logic [7:0] held;
    forever begin
      @(negedge clk);
      if (rst_n && bus.send_byte) begin
        held = bus.byte_to_send;
        tx_busy = 1'b1;
        repeat (tx_delay) @(posedge clk);
        #1;
        chk("tx_hold", bus.byte_to_send, held);
        bus.byte_sent = 1'b1;
        last_done_cyc = cyc;
        done_cnt++;
        @(posedge clk);
        #1 bus.byte_sent = 1'b0;
        tx_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_stream = 1'b0;
    m_intelli = 1'b0;
    m_rate_arg = 1'b0;
    m_rate = 8'h64;
    m_hist.delete();
  endtask

  task automatic model_rx(input logic [7:0] b, input logic [1:0] err);
    if (err != 2'b00) begin
      exp_q.push_back(8'hFE);
    end else if (m_rate_arg) begin
      exp_q.push_back(8'hFA);
      m_rate = b;
      m_hist.push_back(b);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      if (m_hist.size() == 3 && m_hist[0] == 8'hC8 && m_hist[1] == 8'h64 && m_hist[2] == 8'h50)
        m_intelli = 1'b1;
      m_rate_arg = 1'b0;
    end else begin
      case (b)
        8'hFF: begin
          exp_q.push_back(8'hFA); exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
          model_reset();
        end
        8'hF4: begin exp_q.push_back(8'hFA); m_stream = 1'b1; end
        8'hF5: begin exp_q.push_back(8'hFA); m_stream = 1'b0; end
        8'hF6: begin exp_q.push_back(8'hFA); m_stream = 1'b0; m_rate = 8'h64; end
        8'hF3: begin exp_q.push_back(8'hFA); m_rate_arg = 1'b1; end
        8'hF2: begin exp_q.push_back(8'hFA); exp_q.push_back(m_intelli ? 8'h03 : 8'h00); end
        default: exp_q.push_back(8'hFE);
      endcase
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", n >= 5000, 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_status();
    chk("streaming", bus.streaming, m_stream);
    chk("intelli_mode", bus.intelli_mode, m_intelli);
    chk("sample_rate", bus.sample_rate, m_rate);
  endtask

  task automatic pulse_rx(input logic [7:0] b, input logic [1:0] err);
    @(posedge clk); #1;
    bus.byte_read = b;
    bus.byte_error_code = err;
    bus.byte_ready = 1'b1;
    @(posedge clk); #1;
    bus.byte_ready = 1'b0;
    bus.byte_error_code = 2'b00;
  endtask

  task automatic host_send(input logic [7:0] b, input logic [1:0] err);
    logic lat0;
    model_rx(b, err);
    pulse_rx(b, err);
    lat0 = bus.send_byte;
    @(posedge clk); #1;
    chk("rx_latency", {30'd0, lat0, bus.send_byte}, 32'd1);
    wait_drain();
    check_status();
  endtask

  task automatic drive_move(input logic [8:0] dx, input logic [8:0] dy,
                            input logic [3:0] dz, input logic [2:0] btn);
    int n = 0;
    @(posedge clk); #1;
    bus.move_dx = dx;
    bus.move_dy = dy;
    bus.move_dz = dz;
    bus.move_buttons = btn;
    bus.move_valid = 1'b1;
    while (!bus.move_accept && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bus.move_valid = 1'b0;
    chk("accept_timeout", n >= 50, 32'd0);
  endtask

  task automatic move(input logic [8:0] dx, input logic [8:0] dy,
                      input logic [3:0] dz, input logic [2:0] btn);
    int x, y, z, acc0;
    x = $signed(dx);
    y = $signed(dy);
    z = $signed(dz);
    exp_q.push_back(8'(8 + btn + (x < 0 ? 16 : 0) + (y < 0 ? 32 : 0)));
    exp_q.push_back(8'(x & 255));
    exp_q.push_back(8'(y & 255));
    if (m_intelli) exp_q.push_back(8'(z & 255));
    acc0 = accept_cnt;
    drive_move(dx, dy, dz, btn);
    wait_drain();
    chk("accept_pulses", accept_cnt - acc0, 32'd1);
  endtask

  initial begin : stimulus
    int base, acc0, n, k, d0;
    bus.byte_sent = 1'b0;
    bus.byte_read = 8'h00;
    bus.byte_ready = 1'b0;
    bus.byte_error_code = 2'b00;
    bus.move_valid = 1'b0;
    bus.move_dx = 9'd0;
    bus.move_dy = 9'd0;
    bus.move_dz = 4'd0;
    bus.move_buttons = 3'd0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_send_byte", bus.send_byte, 32'd0);
    chk("rst_byte_to_send", bus.byte_to_send, 32'h00);
    chk("rst_move_accept", bus.move_accept, 32'd0);
    check_status();
    @(negedge clk) rst_n = 1'b1;

    // Reset command, streaming packet, IntelliMouse handshake.
    host_send(8'hFF, 2'b00);
    host_send(8'hF4, 2'b00);
    move(9'h1FD, 9'h005, 4'h0, 3'b001);
    host_send(8'hF3, 2'b00); host_send(8'hC8, 2'b00);
    host_send(8'hF3, 2'b00); host_send(8'h64, 2'b00);
    host_send(8'hF3, 2'b00); host_send(8'h50, 2'b00);
    host_send(8'hF2, 2'b00);
    move(9'h002, 9'h1FE, 4'hF, 3'b110);

    // Broken magic sequence leaves standard mode.
    host_send(8'hFF, 2'b00);
    host_send(8'hF3, 2'b00); host_send(8'hC8, 2'b00);
    host_send(8'hF3, 2'b00); host_send(8'h0A, 2'b00);
    host_send(8'hF3, 2'b00); host_send(8'h50, 2'b00);
    host_send(8'hF2, 2'b00);

    // Error handling, including a bad byte while a rate argument is expected.
    host_send(8'hF4, 2'b00);
    host_send(8'hF4, 2'b01);
    host_send(8'hE9, 2'b00);
    host_send(8'hF3, 2'b00);
    host_send(8'h28, 2'b11);
    host_send(8'h28, 2'b00);
    host_send(8'hF6, 2'b00);

    for (int i = 0; i < 40; i++) begin
      tx_delay = int'($urandom_range(1, 4));
      k = int'($urandom_range(0, 7));
      if (m_rate_arg) begin
        host_send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 1)));
      end else begin
        case (k)
          0: host_send(8'hF4, 2'b00);
          1: host_send(8'hF5, 2'b00);
          2: host_send(8'hF2, 2'b00);
          3: host_send(8'hF3, 2'b00);
          4: host_send(8'($urandom_range(0, 255)), 2'($urandom_range(1, 3)));
          5: host_send(8'($urandom_range(0, 255)), 2'b00);
          default: begin
            if (m_stream)
              move(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                   4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            else
              host_send(8'hF4, 2'b00);
          end
        endcase
      end
    end

    // Host priority: F5 arrives while packet byte 1 is in flight.
    if (m_rate_arg) host_send(8'h28, 2'b00);
    host_send(8'hF4, 2'b00);
    tx_delay = 8;
    exp_q.push_back(8'h2C);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'hFA);
    m_stream = 1'b0;
    base = sent_cnt;
    acc0 = accept_cnt;
    drive_move(9'h010, 9'h1F0, 4'h0, 3'b100);
    n = 0;
    while (sent_cnt < base + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("prio_wait_timeout", n >= 200, 32'd0);
    pulse_rx(8'hF5, 2'b00);
    wait_drain();
    repeat (20) @(posedge clk);
    #1;
    chk("prio_extra_bytes", sent_cnt - base, 32'd3);
    chk("prio_accepts", accept_cnt - acc0, 32'd1);
    check_status();
    tx_delay = 2;

    // Asynchronous reset in the middle of the self-test wait.
    host_send(8'hF4, 2'b00);
    exp_q.push_back(8'hFA);
    model_reset();
    d0 = done_cnt;
    pulse_rx(8'hFF, 2'b00);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("selftest_ack_timeout", n >= 200, 32'd0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_send_byte", bus.send_byte, 32'd0);
    chk("arst_byte_to_send", bus.byte_to_send, 32'h00);
    chk("arst_move_accept", bus.move_accept, 32'd0);
    check_status();
    @(negedge clk) rst_n = 1'b1;
    repeat (2 * ST) @(posedge clk);
    #1;
    chk("arst_no_resume", exp_q.size(), 32'd0);
    check_status();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
